// File: rtl/dense_layer2_mac.sv
// Layer-2 dense stage: OUT_SIZE sequential dot products on one shared signed multiplier,
// each rescaled by SHIFT and saturated to OUT_W. Optional argmax enabled by `define ARGMAX_EN.
module dense_layer2_mac #(
   parameter int unsigned IN_SIZE  = 16,
   parameter int unsigned OUT_SIZE = 10,
   parameter int unsigned W        = 8,
   parameter int unsigned ACC_W    = 24,
   parameter int unsigned SHIFT    = 7,
   parameter int unsigned OUT_W    = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            weights_valid,
   input  logic [IN_SIZE*OUT_SIZE*W-1:0]   weights,
   input  logic [IN_SIZE*W-1:0]            act_in,
   output logic [OUT_SIZE*OUT_W-1:0]       result,
   output logic [$clog2(OUT_SIZE)-1:0]     class_idx,
   output logic                            busy,
   output logic                            done
);

   localparam int unsigned I_W = $clog2(IN_SIZE);
   localparam int unsigned O_W = $clog2(OUT_SIZE);
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [2:0] {S_IDLE, S_WAIT_W, S_MAC, S_STORE, S_DONE} state_t;

   state_t                    state_q, state_d;
   logic [IN_SIZE*W-1:0]      act_q, act_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [I_W-1:0]            i_q, i_d;
   logic [O_W-1:0]            o_q, o_d;
   logic [OUT_SIZE*OUT_W-1:0] result_q, result_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;

   logic signed [W-1:0]       act_sel_c;
   logic signed [W-1:0]       w_sel_c;
   logic signed [2*W-1:0]     prod_c;
   logic signed [ACC_W-1:0]   shifted_c;
   logic signed [OUT_W-1:0]   sat_c;

   assign act_sel_c = act_q[int'(i_q)*W +: W];
   assign w_sel_c   = weights[(int'(o_q)*IN_SIZE + int'(i_q))*W +: W];
   assign prod_c    = act_sel_c * w_sel_c;
   assign shifted_c = acc_q >>> SHIFT;

   // Clamp the rescaled accumulator into the signed OUT_W range
   always_comb begin
      if (shifted_c > SAT_MAX)      sat_c = OUT_W'(SAT_MAX);
      else if (shifted_c < SAT_MIN) sat_c = OUT_W'(SAT_MIN);
      else                          sat_c = OUT_W'(shifted_c);
   end

`ifdef ARGMAX_EN
   logic signed [OUT_W-1:0] best_val_q, best_val_d;
   logic [O_W-1:0]          class_idx_q, class_idx_d;
`endif

   always_comb begin
      state_d  = state_q;
      act_d    = act_q;
      acc_d    = acc_q;
      i_d      = i_q;
      o_d      = o_q;
      result_d = result_q;
      busy_d   = (state_q == S_WAIT_W) || (state_q == S_MAC) || (state_q == S_STORE);
      done_d   = (state_q == S_DONE);
`ifdef ARGMAX_EN
      best_val_d  = best_val_q;
      class_idx_d = class_idx_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               act_d    = act_in;
               acc_d    = '0;
               i_d      = '0;
               o_d      = '0;
               result_d = '0;
               done_d   = 1'b0;
`ifdef ARGMAX_EN
               best_val_d  = '0;
               class_idx_d = '0;
`endif
               state_d  = weights_valid ? S_MAC : S_WAIT_W;
            end
         end
         S_WAIT_W: begin
            if (weights_valid) state_d = S_MAC;
         end
         S_MAC: begin
            acc_d = acc_q + ACC_W'(prod_c);
            if (i_q == I_W'(IN_SIZE - 1)) begin
               i_d     = '0;
               state_d = S_STORE;
            end else begin
               i_d = i_q + I_W'(1);
            end
         end
         S_STORE: begin
            result_d[int'(o_q)*OUT_W +: OUT_W] = sat_c;
            acc_d = '0;
`ifdef ARGMAX_EN
            // Strict greater-than keeps the lower index on ties
            if ((o_q == '0) || (sat_c > best_val_q)) begin
               best_val_d  = sat_c;
               class_idx_d = o_q;
            end
`endif
            if (o_q == O_W'(OUT_SIZE - 1)) begin
               state_d = S_DONE;
            end else begin
               o_d     = o_q + O_W'(1);
               state_d = S_MAC;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         act_q    <= '0;
         acc_q    <= '0;
         i_q      <= '0;
         o_q      <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef ARGMAX_EN
         best_val_q  <= '0;
         class_idx_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         act_q    <= act_d;
         acc_q    <= acc_d;
         i_q      <= i_d;
         o_q      <= o_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef ARGMAX_EN
         best_val_q  <= best_val_d;
         class_idx_q <= class_idx_d;
`endif
      end
   end

   assign result = result_q;
   assign busy   = busy_q;
   assign done   = done_q;
`ifdef ARGMAX_EN
   assign class_idx = class_idx_q;
`else
   assign class_idx = '0;
`endif

endmodule

// File: tb/tb_dense_layer2_mac.sv
// Directed bench for dense_layer2_mac at default parameters; honours `define ARGMAX_EN.
module tb_dense_layer2_mac;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          weights_valid;
   logic [1279:0] weights;
   logic [127:0]  act_in;
   logic [79:0]   result;
   logic [3:0]    class_idx;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_r [10];
   int n, nb;

   dense_layer2_mac dut (
      .clk(clk), .rst(rst), .start(start), .weights_valid(weights_valid),
      .weights(weights), .act_in(act_in), .result(result),
      .class_idx(class_idx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_w(input int o, input logic [7:0] v);
      for (int i = 0; i < 16; i++) weights[(o*16+i)*8 +: 8] = v;
   endtask

   task automatic set_acts(input logic [7:0] v);
      for (int i = 0; i < 16; i++) act_in[i*8 +: 8] = v;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Counts edges from the current sample until done, and busy samples seen on the way
   task automatic wait_done(input int n0, output int cnt, output int bcnt);
      cnt  = n0;
      bcnt = 0;
      while (!done && cnt < 400) begin
         if (busy) bcnt++;
         tick();
         cnt++;
      end
   endtask

   task automatic check_res(input string t);
      for (int o = 0; o < 10; o++)
         check($sformatf("%s_r%0d", t, o), 32'(result[o*8 +: 8]), 32'(exp_r[o]));
   endtask

   function automatic logic [31:0] exp_cls(input int v);
`ifdef ARGMAX_EN
      return 32'(v);
`else
      return 32'(v * 0);
`endif
   endfunction

   initial begin
      rst = 1'b1; start = 1'b0; weights_valid = 1'b0; weights = '0; act_in = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_result", 32'(result == '0), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      tick();
      check("idle_done", 32'(done), 32'd0);
      check("idle_cls", 32'(class_idx), 32'd0);

      // 16*8*16 = 2048 >>> 7 = 16 for every neuron
      for (int o = 0; o < 10; o++) begin set_w(o, 8'd16); exp_r[o] = 8'd16; end
      set_acts(8'd8);
      weights_valid = 1'b1;
      pulse_start();
      wait_done(0, n, nb);
      check("t1_latency", 32'(n), 32'd171);
      check("t1_busy_cycles", 32'(nb), 32'd170);
      check_res("t1");
      check("t1_cls", 32'(class_idx), exp_cls(0));

      // weight(o,i)=o, acts=8 -> 128*o >>> 7 = o
      for (int o = 0; o < 10; o++) begin set_w(o, 8'(o)); exp_r[o] = 8'(o); end
      pulse_start();
      check("t2_done_drop", 32'(done), 32'd0);
      wait_done(0, n, nb);
      check("t2_latency", 32'(n), 32'd171);
      check_res("t2");
      check("t2_cls", 32'(class_idx), exp_cls(9));

      // +258064 >>> 7 = 2016 -> 127 ; -260096 >>> 7 = -2032 -> -128
      for (int o = 0; o < 10; o++) begin
         set_w(o, (o % 2 == 1) ? 8'h80 : 8'h7f);
         exp_r[o] = (o % 2 == 1) ? 8'h80 : 8'h7f;
      end
      set_acts(8'h7f);
      pulse_start();
      wait_done(0, n, nb);
      check_res("t3");
      check("t3_cls", 32'(class_idx), exp_cls(0));

      // Hold in WAIT_W until weights become valid
      for (int o = 0; o < 10; o++) begin set_w(o, 8'(o)); exp_r[o] = 8'(o); end
      set_acts(8'd8);
      weights_valid = 1'b0;
      pulse_start();
      repeat (20) tick();
      check("t4_wait_busy", 32'(busy), 32'd1);
      check("t4_wait_done", 32'(done), 32'd0);
      weights_valid = 1'b1;
      tick();
      wait_done(0, n, nb);
      check("t4_latency", 32'(n), 32'd171);
      check_res("t4");

      // Start while busy is ignored; act_in changes after latching are ignored
      pulse_start();
      set_acts(8'd0);
      repeat (50) tick();
      pulse_start();
      wait_done(51, n, nb);
      check("t5_latency", 32'(n), 32'd171);
      check_res("t5");
      set_acts(8'd8);
      pulse_start();
      check("t5_restart_done", 32'(done), 32'd0);
      wait_done(0, n, nb);
      check("t5_restart_lat", 32'(n), 32'd171);
      check_res("t5b");

      // Asynchronous reset mid-run, then restart with a tie between neurons 3 and 7
      pulse_start();
      repeat (60) tick();
      #2 rst = 1'b1;
      #1;
      check("t6_rst_result", 32'(result == '0), 32'd1);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_done", 32'(done), 32'd0);
      check("t6_rst_cls", 32'(class_idx), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int o = 0; o < 10; o++) begin
         set_w(o, (o == 3 || o == 7) ? 8'd40 : 8'(o));
         exp_r[o] = (o == 3 || o == 7) ? 8'd40 : 8'(o);
      end
      pulse_start();
      wait_done(0, n, nb);
      check("t6_latency", 32'(n), 32'd171);
      check_res("t6");
      check("t6_cls", 32'(class_idx), exp_cls(3));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
